addr_bus_sequencer: RTL and testbench

//  Parametrised successor to the CPU address-bus mux: selects one of NSRC address sources onto

---
 rtl/addr_bus_sequencer_if.sv | 33 +++
 rtl/addr_bus_sequencer.sv | 114 +++++++++++
 tb/tb_addr_bus_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/addr_bus_sequencer_if.sv
// Bus bundle for addr_bus_sequencer: core/debug address sources in, address,
// lane enables and access-sequencing status out.
interface addr_bus_sequencer_if #(
  parameter int AW   = 16,
  parameter int NSRC = 5,
  parameter int SELW = 3
);
  logic                 FETCH;
  logic                 DECODE;
  logic                 BYTEX;
  logic [SELW-1:0]      ADDR_SEL;
  logic [NSRC*AW-1:0]   SRC_ADDR;
  logic                 START;
  logic                 MEM_WAIT;
  logic                 DEBUG_REQ;
  logic                 DEBUG_GNT;
  logic [AW-1:0]        ADDR;
  logic [1:0]           BYTE_EN;
  logic                 HIGH_BYTEX;
  logic                 STALL;
  logic                 DONE;
  logic                 START_ERR;

  modport master (
    output FETCH, DECODE, BYTEX, ADDR_SEL, SRC_ADDR, START, MEM_WAIT, DEBUG_REQ,
    input  DEBUG_GNT, ADDR, BYTE_EN, HIGH_BYTEX, STALL, DONE, START_ERR
  );

  modport slave (
    input  FETCH, DECODE, BYTEX, ADDR_SEL, SRC_ADDR, START, MEM_WAIT, DEBUG_REQ,
    output DEBUG_GNT, ADDR, BYTE_EN, HIGH_BYTEX, STALL, DONE, START_ERR
  );
endinterface

// File: rtl/addr_bus_sequencer.sv
// Address-bus source mux with wait-state access sequencing, debugger bus
// ownership handshake and byte-lane enable generation.
module addr_bus_sequencer #(
  parameter int AW          = 16,
  parameter int NSRC        = 5,
  parameter int SELW        = 3,
  parameter int PC_SRC      = 0,
  parameter int DEBUG_SRC   = 4,
  parameter int DEFAULT_SRC = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic CLK,
  input  logic RESET,
  addr_bus_sequencer_if.slave bus
);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] sel_q, sel_d, next_sel;
  logic            gnt_q, gnt_d;
  logic            err_q, err_d;
  logic            busy, done, stall;
  logic [AW-1:0]   addr;
  logic [1:0]      byte_en;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= SELW'(PC_SRC);
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    if (gnt_q)
      next_sel = SELW'(DEBUG_SRC);
    else if (bus.FETCH || bus.DECODE)
      next_sel = SELW'(PC_SRC);
    else if (32'(bus.ADDR_SEL) < 32'(NSRC))
      next_sel = bus.ADDR_SEL;
    else
      next_sel = SELW'(DEFAULT_SRC);

    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = BUSY;
          cnt_d   = CW'(WAIT_STATES);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!bus.MEM_WAIT) begin
          // Completion cycle doubles as the accept slot for a back-to-back access
          if (bus.START) cnt_d = CW'(WAIT_STATES);
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || done) sel_d = next_sel;

    // Grant only from IDLE so a same-cycle START keeps the bus for the core
    if (gnt_q) begin
      if (!bus.DEBUG_REQ && (state_q == IDLE || done)) gnt_d = 1'b0;
    end else if (state_q == IDLE && bus.DEBUG_REQ && !bus.START) begin
      gnt_d = 1'b1;
    end

    if (stall && bus.START) err_d = 1'b1;
  end

  always_comb begin
    busy  = (state_q == BUSY);
    done  = busy && (cnt_q == '0) && !bus.MEM_WAIT;
    stall = busy && !done;

    addr = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (sel_q == SELW'(i)) addr = bus.SRC_ADDR[i*AW +: AW];
    end

    if (!bus.BYTEX)  byte_en = 2'b11;
    else if (addr[0]) byte_en = 2'b10;
    else              byte_en = 2'b01;
  end

  assign bus.ADDR       = addr;
  assign bus.BYTE_EN    = byte_en;
  assign bus.HIGH_BYTEX = addr[0] & bus.BYTEX;
  assign bus.STALL      = stall;
  assign bus.DONE       = done;
  assign bus.DEBUG_GNT  = gnt_q;
  assign bus.START_ERR  = err_q;
endmodule

// File: tb/tb_addr_bus_sequencer.sv
// Directed bench for addr_bus_sequencer: scoreboard of expected DONE cycle and
// address per accepted START, plus point checks of status outputs.
module tb_addr_bus_sequencer;
  localparam int AW   = 16;
  localparam int NSRC = 5;
  localparam int SELW = 3;
  localparam int WS   = 2;

  localparam logic [AW-1:0] S0 = 16'h0100;
  localparam logic [AW-1:0] S1 = 16'h1111;
  localparam logic [AW-1:0] S2 = 16'h2200;
  localparam logic [AW-1:0] S3 = 16'h2A01;
  localparam logic [AW-1:0] S4 = 16'h4444;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  addr_bus_sequencer_if #(.AW(AW), .NSRC(NSRC), .SELW(SELW)) bus ();

  addr_bus_sequencer #(
    .AW(AW), .NSRC(NSRC), .SELW(SELW), .PC_SRC(0), .DEBUG_SRC(4),
    .DEFAULT_SRC(2), .WAIT_STATES(WS)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  exp_t sb[$];
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge; START is a pulse.
  task automatic cyc_begin();
    @(posedge CLK);
    #2;
    cycle++;
    bus.START = 1'b0;
  endtask

  // Let inputs settle, then retire any completed access against the scoreboard.
  task automatic sample();
    exp_t e;
    #1;
    if (sb.size() != 0 && cycle > sb[0].cyc) begin
      e = sb.pop_front();
      check("done_missing", 32'(cycle), 32'(e.cyc));
    end
    if (bus.DONE === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.DONE), 32'(0));
      end else begin
        e = sb.pop_front();
        check("done_cycle", 32'(cycle), 32'(e.cyc));
        check("done_addr", 32'(bus.ADDR), 32'(e.addr));
      end
    end
  endtask

  task automatic push(input int lat, input logic [AW-1:0] a);
    exp_t e;
    e.cyc  = cycle + lat;
    e.addr = a;
    sb.push_back(e);
  endtask

  initial begin
    bit seen;
    RESET         = 1'b1;
    bus.FETCH     = 1'b0;
    bus.DECODE    = 1'b0;
    bus.BYTEX     = 1'b0;
    bus.ADDR_SEL  = '0;
    bus.SRC_ADDR  = {S4, S3, S2, S1, S0};
    bus.START     = 1'b0;
    bus.MEM_WAIT  = 1'b0;
    bus.DEBUG_REQ = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #1 RESET = 1'b0;
    #2;
    check("rst_addr", 32'(bus.ADDR), 32'(S0));
    check("rst_stall", 32'(bus.STALL), 32'(0));
    check("rst_done", 32'(bus.DONE), 32'(0));
    check("rst_gnt", 32'(bus.DEBUG_GNT), 32'(0));
    check("rst_err", 32'(bus.START_ERR), 32'(0));
    cyc_begin(); sample();
    RESET = 1'b1;
    cyc_begin(); sample();

    // Fetch access: PC source wins over ADDR_SEL, DONE at n+1+WS
    cyc_begin();
    bus.FETCH = 1'b1; bus.ADDR_SEL = 3'd3; bus.START = 1'b1;
    push(1 + WS, S0);
    sample();
    check("f_idle_stall", 32'(bus.STALL), 32'(0));
    for (int k = 0; k < WS; k++) begin
      cyc_begin(); sample();
      check("f_stall", 32'(bus.STALL), 32'(1));
      check("f_addr", 32'(bus.ADDR), 32'(S0));
      check("f_lanes", 32'(bus.BYTE_EN), 32'(2'b11));
    end
    cyc_begin(); sample();
    check("f_done_stall", 32'(bus.STALL), 32'(0));

    // Execute access on SRC3, byte, three MEM_WAIT cycles; ADDR_SEL change held off
    cyc_begin(); bus.FETCH = 1'b0; bus.BYTEX = 1'b1; sample();
    cyc_begin(); sample();
    check("x_addr", 32'(bus.ADDR), 32'(S3));
    check("x_lanes", 32'(bus.BYTE_EN), 32'(2'b10));
    check("x_hibyte", 32'(bus.HIGH_BYTEX), 32'(1));
    bus.START = 1'b1;
    push(1 + WS + 3, S3);
    for (int k = 0; k < WS + 3; k++) begin
      cyc_begin(); bus.MEM_WAIT = 1'b1; bus.ADDR_SEL = 3'd1; sample();
      check("x_wait_stall", 32'(bus.STALL), 32'(1));
      check("x_wait_addr", 32'(bus.ADDR), 32'(S3));
    end
    cyc_begin(); bus.MEM_WAIT = 1'b0; sample();
    cyc_begin(); bus.ADDR_SEL = 3'd7; sample();
    check("x_sel1", 32'(bus.ADDR), 32'(S1));
    cyc_begin(); bus.ADDR_SEL = 3'd5; sample();
    check("x_sel7_default", 32'(bus.ADDR), 32'(S2));
    check("x_lanes_lo", 32'(bus.BYTE_EN), 32'(2'b01));
    check("x_hibyte_lo", 32'(bus.HIGH_BYTEX), 32'(0));
    cyc_begin(); bus.ADDR_SEL = 3'd1; sample();
    check("x_sel5_default", 32'(bus.ADDR), 32'(S2));

    // Back-to-back access plus START while busy
    cyc_begin(); bus.BYTEX = 1'b0; bus.START = 1'b1; push(1 + WS, S1); sample();
    cyc_begin(); bus.START = 1'b1; sample();
    check("b_err_pre", 32'(bus.START_ERR), 32'(0));
    cyc_begin(); sample();
    check("b_err_set", 32'(bus.START_ERR), 32'(1));
    cyc_begin(); bus.START = 1'b1; bus.ADDR_SEL = 3'd3; push(1 + WS, S3); sample();
    check("b_done", 32'(bus.DONE), 32'(1));
    cyc_begin(); sample();
    check("b_no_gap", 32'(bus.STALL), 32'(1));
    check("b_addr2", 32'(bus.ADDR), 32'(S3));
    for (int k = 0; k < WS; k++) begin cyc_begin(); sample(); end
    cyc_begin(); sample();
    check("b_err_sticky", 32'(bus.START_ERR), 32'(1));

    // Debug request during a core access: grant only after that access completes
    cyc_begin(); bus.ADDR_SEL = 3'd1; bus.START = 1'b1; push(1 + WS, S1); sample();
    for (int k = 0; k < WS + 1; k++) begin
      cyc_begin(); bus.DEBUG_REQ = 1'b1; sample();
      check("d_no_gnt", 32'(bus.DEBUG_GNT), 32'(0));
    end
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      cyc_begin(); sample();
      seen = bus.DEBUG_GNT;
    end
    check("d_gnt", 32'(seen), 32'(1));
    cyc_begin(); sample();
    check("d_addr", 32'(bus.ADDR), 32'(S4));
    bus.START = 1'b1; push(1 + WS, S4);
    for (int k = 0; k < WS + 1; k++) begin
      cyc_begin(); sample();
      check("d_gnt_hold", 32'(bus.DEBUG_GNT), 32'(1));
    end
    cyc_begin(); bus.DEBUG_REQ = 1'b0; sample();
    check("d_gnt_pre_drop", 32'(bus.DEBUG_GNT), 32'(1));
    cyc_begin(); sample();
    check("d_gnt_drop", 32'(bus.DEBUG_GNT), 32'(0));
    cyc_begin(); sample();
    check("d_addr_back", 32'(bus.ADDR), 32'(S1));

    // Reset mid-access aborts without a DONE
    cyc_begin(); bus.START = 1'b1; sample();
    cyc_begin(); sample();
    cyc_begin(); sample();
    RESET = 1'b0;
    #1;
    check("r_stall", 32'(bus.STALL), 32'(0));
    check("r_done", 32'(bus.DONE), 32'(0));
    check("r_addr", 32'(bus.ADDR), 32'(S0));
    check("r_err", 32'(bus.START_ERR), 32'(0));
    cyc_begin(); RESET = 1'b1; sample();
    for (int k = 0; k < 5; k++) begin
      cyc_begin(); sample();
      check("r_idle", 32'(bus.STALL), 32'(0));
    end

    check("sb_drain", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
